// File: rtl/tx_os_pkg.sv
// Shared constants, state encoding and width helpers for the TX ordered-set arbiter.
package tx_os_pkg;

  localparam logic [7:0] COM_SYM = 8'hBC;
  localparam logic [7:0] SKP_SYM = 8'h1C;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    SKP  = 2'd2
  } tx_state_e;

  // Bytes per word for a gasket width; anything unrecognised behaves as 8-bit.
  function automatic logic [2:0] bpw_of(input logic [5:0] width);
    case (width)
      6'd16:   return 3'd2;
      6'd32:   return 3'd4;
      default: return 3'd1;
    endcase
  endfunction

  function automatic logic [31:0] data_mask(input logic [2:0] bpw);
    case (bpw)
      3'd4:    return 32'hFFFF_FFFF;
      3'd2:    return 32'h0000_FFFF;
      default: return 32'h0000_00FF;
    endcase
  endfunction

  function automatic logic [3:0] k_mask(input logic [2:0] bpw);
    case (bpw)
      3'd4:    return 4'hF;
      3'd2:    return 4'h3;
      default: return 4'h1;
    endcase
  endfunction

endpackage

// File: rtl/tx_os_skp_timer.sv
// Symbol counter that advances by bytes-per-word and flags when a SKP set is due.
module tx_skp_timer #(
  parameter int unsigned SKP_INTERVAL = 1180,
  parameter int unsigned CNT_W        = 12
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       adv,
  input  logic [2:0] inc,
  output logic       skp_due_c
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W:0]   sum_c;

  assign sum_c     = {1'b0, cnt_q} + (CNT_W+1)'(inc);
  assign skp_due_c = sum_c >= (CNT_W+1)'(SKP_INTERVAL);

  // Counter restarts on every SKP entry, so it never wraps.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr || (adv && skp_due_c)) begin
      cnt_q <= '0;
    end else if (adv) begin
      cnt_q <= sum_c[CNT_W-1:0];
    end
  end

endmodule

// File: rtl/tx_os_arbiter.sv
// Muxes MAC words and periodic SKP ordered sets onto the TX gasket input.
// Define SKP_COUNT_EN to add the saturating Skp_Count output.
module tx_os_arbiter
  import tx_os_pkg::*;
#(
  parameter int unsigned SKP_INTERVAL = 1180,
  parameter int unsigned CNT_W        = 12
) (
  input  logic        PCLK,
  input  logic        Reset_n,
  input  logic        Link_En,
  input  logic [5:0]  DataBusWidth,
  input  logic [31:0] MAC_TX_Data,
  input  logic [3:0]  MAC_TX_DataK,
  input  logic        MAC_Valid,
  output logic        MAC_Ready,
  output logic [31:0] Gsk_TX_Data,
  output logic [3:0]  Gsk_TX_DataK,
  output logic        Gsk_Data_En,
  output logic        Skp_Active
`ifdef SKP_COUNT_EN
  ,
  output logic [15:0] Skp_Count
`endif
);

  tx_state_e   state_q, state_d;
  logic [2:0]  bpw_q, bpw_d;
  logic [1:0]  skp_idx_q, skp_idx_d;
  logic [31:0] data_d;
  logic [3:0]  k_d;
  logic        en_d, act_d;
  logic        cnt_adv, cnt_clr, skp_due_c, skp_last_c, skp_start_c;
  logic [31:0] skp_word_c;

  tx_skp_timer #(
    .SKP_INTERVAL(SKP_INTERVAL),
    .CNT_W       (CNT_W)
  ) u_timer (
    .clk      (PCLK),
    .rst_n    (Reset_n),
    .clr      (cnt_clr),
    .adv      (cnt_adv),
    .inc      (bpw_q),
    .skp_due_c(skp_due_c)
  );

  assign MAC_Ready = (state_q == DATA);

  // COM leads the set; every later symbol position carries SKP.
  assign skp_word_c = {SKP_SYM, SKP_SYM, SKP_SYM, (skp_idx_q == 2'd0) ? COM_SYM : SKP_SYM};

  always_comb begin
    case (bpw_q)
      3'd4:    skp_last_c = 1'b1;
      3'd2:    skp_last_c = (skp_idx_q == 2'd1);
      default: skp_last_c = (skp_idx_q == 2'd3);
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (!Reset_n) begin
      state_q      <= IDLE;
      bpw_q        <= 3'd1;
      skp_idx_q    <= 2'd0;
      Gsk_TX_Data  <= '0;
      Gsk_TX_DataK <= '0;
      Gsk_Data_En  <= 1'b0;
      Skp_Active   <= 1'b0;
    end else begin
      state_q      <= state_d;
      bpw_q        <= bpw_d;
      skp_idx_q    <= skp_idx_d;
      Gsk_TX_Data  <= data_d;
      Gsk_TX_DataK <= k_d;
      Gsk_Data_En  <= en_d;
      Skp_Active   <= act_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bpw_d     = bpw_q;
    skp_idx_d = 2'd0;
    data_d    = '0;
    k_d       = '0;
    en_d      = 1'b0;
    act_d     = 1'b0;
    cnt_adv   = 1'b0;
    cnt_clr   = 1'b1;
    if (!Link_En) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = DATA;
          bpw_d   = bpw_of(DataBusWidth);
        end
        DATA: begin
          en_d    = 1'b1;
          cnt_adv = 1'b1;
          cnt_clr = 1'b0;
          if (MAC_Valid) begin
            data_d = MAC_TX_Data & data_mask(bpw_q);
            k_d    = MAC_TX_DataK & k_mask(bpw_q);
          end
          if (skp_due_c) state_d = SKP;
        end
        SKP: begin
          en_d      = 1'b1;
          act_d     = 1'b1;
          data_d    = skp_word_c & data_mask(bpw_q);
          k_d       = k_mask(bpw_q);
          skp_idx_d = skp_idx_q + 2'd1;
          if (skp_last_c) begin
            state_d   = DATA;
            skp_idx_d = 2'd0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign skp_start_c = Link_En && (state_q == DATA) && skp_due_c;

`ifdef SKP_COUNT_EN
  always_ff @(posedge PCLK) begin
    if (!Reset_n) begin
      Skp_Count <= '0;
    end else if (skp_start_c && (Skp_Count != 16'hFFFF)) begin
      Skp_Count <= Skp_Count + 16'd1;
    end
  end
`else
  logic unused_skp_start;
  assign unused_skp_start = skp_start_c;
`endif

endmodule

// File: doc/tx_os_arbiter.md
Name: tx_os_arbiter

Overview:
- Shares the TX byte-gasket input between two sources: MAC data words and an internally generated SKP ordered set.
- Inserts one SKP ordered set after every SKP_INTERVAL transmitted symbols and back-pressures the MAC while the set is sent.
- Sits in the PCLK domain, directly upstream of the gasket. Drives the gasket's word, K-flags and data-enable.

Parameters:
- SKP_INTERVAL, 1180, number of symbols transmitted between SKP ordered sets (must be ≥ 8).
- CNT_W, 12, width of the symbol counter (must satisfy 2^CNT_W > SKP_INTERVAL+4).

Ports:
- PCLK  in  1  single clock for the block.
- Reset_n  in  1  synchronous, active-low reset.
- Link_En  in  1  enables transmission; low forces IDLE.
- DataBusWidth  in  6  8/16/32; any other value is treated as 8.
- MAC_TX_Data  in  32  MAC word; byte 0 is transmitted first.
- MAC_TX_DataK  in  4  per-byte K flags.
- MAC_Valid  in  1  MAC word valid.
- MAC_Ready  out  1  word accepted when MAC_Valid && MAC_Ready.
- Gsk_TX_Data  out  32  word to the gasket.
- Gsk_TX_DataK  out  4  K flags to the gasket.
- Gsk_Data_En  out  1  gasket data enable.
- Skp_Active  out  1  high while Gsk_TX_Data carries SKP symbols.
- Skp_Count  out  16  (SKP_COUNT_EN only) number of SKP sets inserted.

Behaviour:
- Reset (sampled on PCLK while Reset_n=0):
  - state=IDLE; all outputs 0; symbol counter 0; latched width = 8.
- Bytes per word (bpw): 1/2/4 for width 8/16/32.
  - Width is latched on the IDLE→DATA transition.
  - Changes to DataBusWidth while in DATA or SKP are ignored.
- States:
  - IDLE: MAC_Ready=0; outputs registered to 0. Link_En=1 → DATA next cycle, counter cleared.
  - DATA: MAC_Ready=1 (combinational from state).
    - Accepted word → registered to the Gsk outputs one cycle later (latency 1); Gsk_Data_En=1.
    - No valid word → logical idle: data 0, K 0, Gsk_Data_En=1.
    - Counter += bpw every DATA cycle. If counter+bpw ≥ SKP_INTERVAL → SKP next cycle, counter cleared.
  - SKP: MAC_Ready=0. Emits COM (8'hBC, K=1) followed by three SKP symbols (8'h1C, K=1) over 4/bpw cycles:
    - 32-bit: one cycle, word 32'h1C1C1CBC, K=4'hF.
    - 16-bit: 16'h1CBC then 16'h1C1C, K=4'b0011, upper bytes 0.
    - 8-bit: BC, 1C, 1C, 1C with K=4'b0001.
    - Skp_Active=1 on the matching output cycles; Gsk_Data_En=1.
    - Counter frozen at 0. After the last SKP cycle → DATA.
- Output register: unused upper bytes and K bits are always zeroed for the latched width.
- Link_En deasserted in any state → IDLE next cycle. An in-progress SKP set is abandoned and the counter cleared. Outputs are 0 from the following cycle.
- Reset mid-SKP or mid-DATA: identical to power-up reset at the next edge.
- Simultaneous SKP-due and MAC_Valid: that cycle's word is still accepted (state is DATA). The SKP set follows directly.
- Counter never wraps: it is cleared on every SKP entry.

Optional Feature:
- SKP_COUNT_EN defined:
  - Skp_Count increments by 1 on each SKP-set start (DATA→SKP transition).
  - Saturates at 16'hFFFF; cleared by reset only.
- SKP_COUNT_EN undefined: Skp_Count port absent, no counter logic.

Decomposition:
- Package tx_os_pkg:
  - COM_SYM=8'hBC, SKP_SYM=8'h1C.
  - State enum {IDLE, DATA, SKP}.
  - Function returning bpw from a 6-bit width.
- One natural sub-module, tx_skp_timer: symbol counter with bpw increment, clear, and a skp_due flag.

Test Plan:
- SKP_INTERVAL=16, width 32, MAC_Valid=1 continuously → 4 data words out, then one 32'h1C1C1CBC/K=F word with Skp_Active=1; MAC_Ready low exactly 1 cycle per 5.
- Width 16, interval 16 → 8 data cycles, then 16'h1CBC and 16'h1C1C (K=0011); MAC_Ready low 2 cycles.
- Width 8, MAC_Valid=0 → idle bytes 0x00, Gsk_Data_En=1; after 16 cycles BC,1C,1C,1C with K=1.
- Link_En dropped on the 2nd cycle of an 8-bit SKP → IDLE, outputs 0. On re-enable, the full interval elapses before the next SKP.
- DataBusWidth changed 32→8 while in DATA → output stays 32-bit until a Link_En toggle; then bpw=1.
- SKP_COUNT_EN, interval 16, width 32, 50 cycles → Skp_Count=10; Reset_n low for 1 cycle → 0.
